// File: rtl/spi_master_n_if.sv
// Control-side handshake plus SPI pin bundle for spi_master_n.
// The slave modport is the master block's view; the master modport is the front end/pins view.
interface spi_master_n_if #(
    parameter int DW   = 10,
    parameter int SSW  = 1,
    parameter int DIVW = 2
);
    localparam int NSS = 1 << SSW;

    logic            start;
    logic            mlb;
    logic            cpol;
    logic            cpha;
    logic [DIVW-1:0] cdiv;
    logic [SSW-1:0]  ssel;
    logic [DW-1:0]   tdat;
    logic            din;
    logic [NSS-1:0]  ss;
    logic            sck;
    logic            dout;
    logic            busy;
    logic            done;
    logic [DW-1:0]   rdata;

    modport master (
        output start, mlb, cpol, cpha, cdiv, ssel, tdat, din,
        input  ss, sck, dout, busy, done, rdata
    );

    modport slave (
        input  start, mlb, cpol, cpha, cdiv, ssel, tdat, din,
        output ss, sck, dout, busy, done, rdata
    );
endinterface

// File: rtl/spi_master_n.sv
// spi_master_n: full-duplex single-word SPI master, any CPOL/CPHA, MSB/LSB first, NSS active-low selects.
// Latency: start sampled at edge 0, ss/busy at edge 1, done at edge 1+(2*DW+1)*(cdiv+1).
// Backpressure: start ignored while busy; SPI_MASTER_LOOPBACK_EN feeds the receive path from dout.
module spi_master_n #(
    parameter int DW   = 10,
    parameter int SSW  = 1,
    parameter int DIVW = 2
) (
    input  logic          clk,
    input  logic          rstb,
    spi_master_n_if.slave bus
);
    localparam int NSS = 1 << SSW;
    localparam int EW  = $clog2(2 * DW);

    typedef enum logic [1:0] {S_IDLE, S_LEAD, S_XFER, S_TRAIL} state_t;

    state_t          r_state;
    logic            r_go;
    logic            r_mlb;
    logic            r_cpol;
    logic            r_cpha;
    logic [DIVW-1:0] r_cdiv;
    logic [DIVW-1:0] r_cnt;
    logic [SSW-1:0]  r_ssel;
    logic [DW-1:0]   r_tx;
    logic [DW-1:0]   r_rx;
    logic [EW-1:0]   r_edge;
    logic [NSS-1:0]  r_ss;
    logic            r_sck;
    logic            r_dout;
    logic            r_busy;
    logic            r_done;
    logic [DW-1:0]   r_rdata;

    logic            w_tick;
    logic            w_tx_bit;
    logic [DW-1:0]   w_tx_next;
    logic            w_rx_bit;
    logic [DW-1:0]   w_rx_next;
    logic            w_lead_edge;
    logic            w_last;
    logic            w_sample;
    logic            w_push;

    assign w_tick      = (r_cnt == '0);
    assign w_tx_bit    = r_mlb ? r_tx[DW-1] : r_tx[0];
    assign w_tx_next   = r_mlb ? {r_tx[DW-2:0], 1'b0} : {1'b0, r_tx[DW-1:1]};
`ifdef SPI_MASTER_LOOPBACK_EN
    assign w_rx_bit    = r_dout;
`else
    assign w_rx_bit    = bus.din;
`endif
    assign w_rx_next   = r_mlb ? {r_rx[DW-2:0], w_rx_bit} : {w_rx_bit, r_rx[DW-1:1]};
    assign w_lead_edge = ~r_edge[0];
    assign w_last      = (r_edge == EW'(2 * DW - 1));
    // Sampling edge is leading for cpha=0 and trailing for cpha=1; the other edge moves dout.
    assign w_sample    = w_lead_edge ^ r_cpha;
    assign w_push      = ~w_sample & (r_cpha | ~w_last);

    always_ff @(posedge clk or posedge rstb) begin
        if (rstb) begin
            r_state <= S_IDLE;
            r_go    <= 1'b0;
            r_mlb   <= 1'b0;
            r_cpol  <= 1'b0;
            r_cpha  <= 1'b0;
            r_cdiv  <= '0;
            r_cnt   <= '0;
            r_ssel  <= '0;
            r_tx    <= '0;
            r_rx    <= '0;
            r_edge  <= '0;
            r_ss    <= '1;
            r_sck   <= 1'b0;
            r_dout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_ss <= '1;
                    if (r_go) begin
                        r_go    <= 1'b0;
                        r_busy  <= 1'b1;
                        r_ss    <= ~(NSS'(1) << r_ssel);
                        r_sck   <= r_cpol;
                        r_cnt   <= r_cdiv;
                        r_edge  <= '0;
                        r_state <= S_LEAD;
                        if (!r_cpha) begin
                            r_dout <= w_tx_bit;
                            r_tx   <= w_tx_next;
                        end
                    end else begin
                        r_sck <= bus.cpol;
                        if (bus.start) begin
                            r_go   <= 1'b1;
                            r_tx   <= bus.tdat;
                            r_mlb  <= bus.mlb;
                            r_cpol <= bus.cpol;
                            r_cpha <= bus.cpha;
                            r_cdiv <= bus.cdiv;
                            r_ssel <= bus.ssel;
                        end
                    end
                end
                S_LEAD, S_XFER: begin
                    if (w_tick) begin
                        r_cnt   <= r_cdiv;
                        r_sck   <= ~r_sck;
                        r_edge  <= r_edge + EW'(1);
                        r_state <= w_last ? S_TRAIL : S_XFER;
                        if (w_sample) begin
                            r_rx <= w_rx_next;
                        end
                        if (w_push) begin
                            r_dout <= w_tx_bit;
                            r_tx   <= w_tx_next;
                        end
                    end else begin
                        r_cnt <= r_cnt - DIVW'(1);
                    end
                end
                S_TRAIL: begin
                    if (w_tick) begin
                        r_ss    <= '1;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_rdata <= r_rx;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - DIVW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.ss    = r_ss;
    assign bus.sck   = r_sck;
    assign bus.dout  = r_dout;
    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
    assign bus.rdata = r_rdata;
endmodule

// File: tb/tb_spi_master_n.sv
// Bench for spi_master_n: timing-formula model checked every cycle plus directed literal expectations.
module tb_spi_master_n;
    localparam int DW   = 10;
    localparam int SSW  = 1;
    localparam int DIVW = 2;
    localparam int NSS  = 1 << SSW;

    logic clk  = 1'b0;
    logic rstb = 1'b1;
    always #5 clk = ~clk;

    spi_master_n_if #(.DW(DW), .SSW(SSW), .DIVW(DIVW)) bus ();
    spi_master_n #(.DW(DW), .SSW(SSW), .DIVW(DIVW)) u_dut (.clk(clk), .rstb(rstb), .bus(bus));

    spi_master_n_if #(.DW(16), .SSW(2), .DIVW(2)) bus16 ();
    spi_master_n #(.DW(16), .SSW(2), .DIVW(2)) u_dut16 (.clk(clk), .rstb(rstb), .bus(bus16));

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // stimulus-side context for the model and the slave
    bit            tb_lb = 1'b1;
    logic [DW-1:0] slave_word = '0;

    // model state
    bit             m_act = 1'b0;
    int             m_c0 = 0;
    int             m_h = 1;
    int             m_n = 0;
    bit             m_cpol, m_cpha, m_mlb;
    logic [SSW-1:0] m_ssel;
    logic [DW-1:0]  m_tdat, m_rx;
    logic [NSS-1:0] e_ss;
    logic           e_sck, e_busy, e_done, e_dv, e_dout;
    logic [DW-1:0]  e_rdata;

    int  rise_cnt = 0, ss_low_cnt = 0, done_cnt = 0;
    bit  prev_sck = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Expected outputs derived from the edge-numbered timing rules of a transfer.
    always @(posedge clk) begin
        int r, d, n, k, j;
        cyc++;
        e_dv = 1'b0;
        if (rstb) begin
            m_act = 1'b0; m_n = 0;
            e_ss = '1; e_sck = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_rdata = '0;
        end else begin
            d = 1 + (2 * DW + 1) * m_h;
            r = cyc - m_c0;
            if ((!m_act || r > d) && bus.start) begin
                m_act = 1'b1; m_c0 = cyc; m_h = int'(bus.cdiv) + 1;
                m_cpol = bus.cpol; m_cpha = bus.cpha; m_mlb = bus.mlb;
                m_ssel = bus.ssel; m_tdat = bus.tdat;
`ifdef SPI_MASTER_LOOPBACK_EN
                m_rx = bus.tdat;
`else
                m_rx = tb_lb ? bus.tdat : slave_word;
`endif
                d = 1 + (2 * DW + 1) * m_h;
                r = 0;
            end
            m_n = 0;
            e_done = 1'b0;
            if (!m_act || r == 0 || r > d) begin
                e_ss = '1; e_busy = 1'b0; e_sck = bus.cpol;
            end else if (r < d) begin
                e_ss = ~(NSS'(1) << m_ssel);
                e_busy = 1'b1;
                n = (r >= 1 + m_h) ? (r - 1) / m_h : 0;
                if (n > 2 * DW) n = 2 * DW;
                m_n = n;
                e_sck = m_cpol ^ n[0];
                if (n > 0 && (r - 1) % m_h == 0) begin
                    k = n - 1;
                    if (((k % 2) == 1) == m_cpha) begin
                        j = k / 2;
                        e_dv = 1'b1;
                        e_dout = m_mlb ? m_tdat[DW-1-j] : m_tdat[j];
                    end
                end
            end else begin
                e_ss = '1; e_busy = 1'b0; e_done = 1'b1; e_sck = m_cpol; e_rdata = m_rx;
            end
        end
        #1;
        chk("ss", bus.ss, e_ss);
        chk("sck", bus.sck, e_sck);
        chk("busy", bus.busy, e_busy);
        chk("done", bus.done, e_done);
        chk("rdata", bus.rdata, e_rdata);
        if (e_dv) chk("dout", bus.dout, e_dout);
        if (bus.sck && !prev_sck && bus.busy) rise_cnt++;
        prev_sck = bus.sck;
        if (bus.ss != '1) ss_low_cnt++;
        if (bus.done) done_cnt++;
    end

    // MISO: loopback of dout, or a slave presenting the next bit after each of its shift edges.
    always @(negedge clk) begin
        int j;
        j = m_cpha ? m_n / 2 : (m_n + 1) / 2;
        if (j > DW - 1) j = DW - 1;
        bus.din = tb_lb ? bus.dout : slave_word[m_mlb ? DW - 1 - j : j];
        bus16.din = bus16.dout;
    end

    task automatic start_xfer(input bit cpol, input bit cpha, input bit mlb, input logic [DIVW-1:0] cdiv,
                              input logic [SSW-1:0] ssel, input logic [DW-1:0] tdat, input bit lb,
                              input logic [DW-1:0] sw, output int t0);
        @(negedge clk);
        bus.cpol = cpol; bus.cpha = cpha; bus.mlb = mlb; bus.cdiv = cdiv;
        bus.ssel = ssel; bus.tdat = tdat; tb_lb = lb; slave_word = sw;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_done(input int t0, output int lat);
        lat = -1;
        for (int i = 0; i < 400; i++) begin
            if (bus.done) begin
                lat = cyc - t0;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int t0, lat, gap, ss_cnt, ss_bad;
        bus.start = 0; bus.mlb = 1; bus.cpol = 0; bus.cpha = 0; bus.cdiv = 0; bus.ssel = 0; bus.tdat = 0;
        bus16.start = 0; bus16.mlb = 1; bus16.cpol = 0; bus16.cpha = 0; bus16.cdiv = 0;
        bus16.ssel = 0; bus16.tdat = 0;
        repeat (3) @(negedge clk);
        chk("rst_ss", bus.ss, 2'b11);
        chk("rst_sck", bus.sck, 1'b0);
        chk("rst_dout", bus.dout, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_rdata", bus.rdata, 10'h000);
        rstb = 1'b0;
        repeat (2) @(negedge clk);

        // mode 0, MSB first, cdiv=0, loopback
        rise_cnt = 0; ss_low_cnt = 0;
        start_xfer(0, 0, 1, 2'd0, 1'b0, 10'b0101010101, 1, 10'h000, t0);
        wait_done(t0, lat);
        chk("t1_done_edge", lat, 22);
        chk("t1_rdata", bus.rdata, 10'b0101010101);
        chk("t1_sck_rises", rise_cnt, 10);
        chk("t1_ss_low_cycles", ss_low_cnt, 21);

        // mode 0, LSB first, cdiv=1
        rise_cnt = 0;
        start_xfer(0, 0, 0, 2'd1, 1'b0, 10'b1010101010, 1, 10'h000, t0);
        @(negedge clk);
        chk("t2_first_dout", bus.dout, 1'b0);
        wait_done(t0, lat);
        chk("t2_done_edge", lat, 43);
        chk("t2_rdata", bus.rdata, 10'b1010101010);
        chk("t2_sck_rises", rise_cnt, 10);

        // mode 3, slave 1 returns 10'h2C5 MSB first
        start_xfer(1, 1, 1, 2'd0, 1'b1, 10'h155, 0, 10'h2C5, t0);
        repeat (5) @(negedge clk);
        chk("t3_ss_mid", bus.ss, 2'b01);
        wait_done(t0, lat);
        chk("t3_done_edge", lat, 22);
`ifdef SPI_MASTER_LOOPBACK_EN
        chk("t3_rdata", bus.rdata, 10'h155);
`else
        chk("t3_rdata", bus.rdata, 10'h2C5);
`endif
        repeat (2) @(negedge clk);
        chk("t3_sck_idle", bus.sck, 1'b1);

        // start pulsed at edge 5 mid-transfer is ignored
        done_cnt = 0;
        start_xfer(0, 0, 1, 2'd0, 1'b0, 10'h3A7, 1, 10'h000, t0);
        repeat (4) @(negedge clk);
        bus.start = 1'b1; bus.tdat = 10'h0F0;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(t0, lat);
        chk("t4_done_edge", lat, 22);
        chk("t4_rdata", bus.rdata, 10'h3A7);
        repeat (25) @(negedge clk);
        chk("t4_done_count", done_cnt, 1);

        // start held high: next word accepted on the first edge with busy low
        @(negedge clk);
        bus.tdat = 10'h2B4; bus.start = 1'b1;
        @(negedge clk);
        t0 = cyc;
        wait_done(t0, lat);
        chk("t5_done_edge", lat, 22);
        gap = 0;
        while (!bus.busy && gap < 10) begin
            gap++;
            @(negedge clk);
        end
        t0 = cyc - 1;
        bus.start = 1'b0;
        chk("t5_busy_gap", gap, 2);
        wait_done(t0, lat);
        chk("t5b_done_edge", lat, 22);
        chk("t5b_rdata", bus.rdata, 10'h2B4);

        // reset at edge 10 of a transfer
        start_xfer(0, 0, 1, 2'd0, 1'b0, 10'h1C3, 1, 10'h000, t0);
        repeat (9) @(negedge clk);
        rstb = 1'b1;
        #1;
        chk("t6_rst_ss", bus.ss, 2'b11);
        chk("t6_rst_sck", bus.sck, 1'b0);
        chk("t6_rst_busy", bus.busy, 1'b0);
        chk("t6_rst_rdata", bus.rdata, 10'h000);
        repeat (2) @(negedge clk);
        rstb = 1'b0;
        done_cnt = 0;
        repeat (30) @(negedge clk);
        chk("t6_no_done", done_cnt, 0);
        start_xfer(0, 0, 1, 2'd0, 1'b0, 10'h24E, 1, 10'h000, t0);
        wait_done(t0, lat);
        chk("t6_done_edge", lat, 22);
        chk("t6_rdata", bus.rdata, 10'h24E);

        // DW=16, SSW=2 instance in loopback, cdiv=3, slave 2
        @(negedge clk);
        bus16.tdat = 16'hA55A; bus16.cdiv = 2'd3; bus16.ssel = 2'd2; bus16.start = 1'b1;
        @(negedge clk);
        bus16.start = 1'b0;
        t0 = cyc; lat = -1; ss_cnt = 0; ss_bad = 0;
        for (int i = 0; i < 400; i++) begin
            if (bus16.ss != 4'hF) begin
                ss_cnt++;
                if (bus16.ss != 4'b1011) ss_bad++;
            end
            if (bus16.done) begin
                lat = cyc - t0;
                break;
            end
            @(negedge clk);
        end
        chk("w16_done_edge", lat, 133);
        chk("w16_rdata", bus16.rdata, 16'hA55A);
        chk("w16_ss_low_cycles", ss_cnt, 132);
        chk("w16_ss_other_asserted", ss_bad, 0);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
